// File: rtl/vga_timing_gen_pkg.sv
// Shared raster types and 640x480@60 timing defaults for the display path.
package vga_timing_gen_pkg;

    localparam int HCOUNT_WIDTH = 11;
    localparam int VCOUNT_WIDTH = 10;

    typedef logic [HCOUNT_WIDTH-1:0] hcount_t;
    typedef logic [VCOUNT_WIDTH-1:0] vcount_t;

    localparam int unsigned DEF_H_VISIBLE   = 32'd640;
    localparam int unsigned DEF_H_FP        = 32'd16;
    localparam int unsigned DEF_H_SYNC      = 32'd96;
    localparam int unsigned DEF_H_BP        = 32'd48;
    localparam int unsigned DEF_V_VISIBLE   = 32'd480;
    localparam int unsigned DEF_V_FP        = 32'd10;
    localparam int unsigned DEF_V_SYNC      = 32'd2;
    localparam int unsigned DEF_V_BP        = 32'd33;
    localparam int unsigned DEF_ALIGN_DELAY = 32'd3;

    typedef struct packed {
        hcount_t hcount;
        vcount_t vcount;
        logic    hsync;
        logic    vsync;
        logic    blank;
    } vga_t;

    localparam vga_t VGA_RESET = '{hcount: '0, vcount: '0, hsync: 1'b1, vsync: 1'b1, blank: 1'b0};

    // True when pos lies in the half-open window [lo, lo+len).
    function automatic logic in_range(input int unsigned pos, input int unsigned lo,
                                      input int unsigned len);
        return (pos >= lo) && (pos < (lo + len));
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bundle between the timing generator (src) and the renderers (dst).
interface vga_if;
    import vga_timing_gen_pkg::*;

    hcount_t hcount;
    vcount_t vcount;
    logic    hsync;
    logic    vsync;
    logic    blank;

    modport src (output hcount, vcount, hsync, vsync, blank);
    modport dst (input  hcount, vcount, hsync, vsync, blank);
endinterface

// File: rtl/vga_delay_line.sv
// Pixel-strobe-enabled shift register of raster samples; built only with VGA_ALIGN_DELAY_EN.
`ifdef VGA_ALIGN_DELAY_EN
module vga_delay_line
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_ALIGN_DELAY
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en,
    input  vga_t din,
    output vga_t dout
);

    vga_t stage_r [DEPTH];

    // Shift one sample per strobe; stages reset to the raster's own reset state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_r[i] <= VGA_RESET;
            end
        end else if (en) begin
            stage_r[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster source; VGA_ALIGN_DELAY_EN adds a strobe-delayed copy on vga_aligned.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
`ifdef VGA_ALIGN_DELAY_EN
    , parameter int unsigned ALIGN_DELAY = DEF_ALIGN_DELAY
`endif
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pix_en,
    output logic frame_done,
    vga_if.src   vga
`ifdef VGA_ALIGN_DELAY_EN
    , vga_if.src vga_aligned
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam hcount_t     H_LAST  = hcount_t'(H_TOTAL - 32'd1);
    localparam vcount_t     V_LAST  = vcount_t'(V_TOTAL - 32'd1);

    vga_t    vga_r;
    logic    frame_done_r;
    hcount_t h_next_s;
    vcount_t v_next_s;
    logic    wrap_s;
    vga_t    vga_next_s;

    // Next raster position, with sync/blank decoded from it so they register alongside the counts.
    always_comb begin
        h_next_s = vga_r.hcount + hcount_t'(1'b1);
        v_next_s = vga_r.vcount;
        wrap_s   = 1'b0;
        if (vga_r.hcount == H_LAST) begin
            h_next_s = '0;
            if (vga_r.vcount == V_LAST) begin
                v_next_s = '0;
                wrap_s   = 1'b1;
            end else begin
                v_next_s = vga_r.vcount + vcount_t'(1'b1);
            end
        end else begin
            v_next_s = vga_r.vcount;
        end
        vga_next_s        = VGA_RESET;
        vga_next_s.hcount = h_next_s;
        vga_next_s.vcount = v_next_s;
        vga_next_s.hsync  = ~in_range(32'(h_next_s), H_VISIBLE + H_FP, H_SYNC);
        vga_next_s.vsync  = ~in_range(32'(v_next_s), V_VISIBLE + V_FP, V_SYNC);
        vga_next_s.blank  = (32'(h_next_s) >= H_VISIBLE) || (32'(v_next_s) >= V_VISIBLE);
    end

    // Raster advances only on a strobe; frame_done is a single clock wide even with gapped strobes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vga_r        <= VGA_RESET;
            frame_done_r <= 1'b0;
        end else if (pix_en) begin
            vga_r        <= vga_next_s;
            frame_done_r <= wrap_s;
        end else begin
            frame_done_r <= 1'b0;
        end
    end

    assign vga.hcount = vga_r.hcount;
    assign vga.vcount = vga_r.vcount;
    assign vga.hsync  = vga_r.hsync;
    assign vga.vsync  = vga_r.vsync;
    assign vga.blank  = vga_r.blank;
    assign frame_done = frame_done_r;

`ifdef VGA_ALIGN_DELAY_EN
    vga_t aligned_s;

    vga_delay_line #(.DEPTH(ALIGN_DELAY)) u_align (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (pix_en),
        .din    (vga_r),
        .dout   (aligned_s)
    );

    assign vga_aligned.hcount = aligned_s.hcount;
    assign vga_aligned.vcount = aligned_s.vcount;
    assign vga_aligned.hsync  = aligned_s.hsync;
    assign vga_aligned.vsync  = aligned_s.vsync;
    assign vga_aligned.blank  = aligned_s.blank;
`endif

endmodule
